// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its helpers.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

  // Burst counter width; covers MAX_BURST up to 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping mod NREQ.
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [ID_W-1:0] pick,
  output logic            any_req
);

  logic [ID_W:0] sum;

  // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
  always_comb begin
    sum     = '0;
    pick    = '0;
    any_req = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      if (req_valid[sum[ID_W-1:0]]) pick = sum[ID_W-1:0];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ producers with round-robin burst grants.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr, owner, pick, owner_inc;
  logic [CNT_W-1:0] burst_cnt;
  logic             any_req, own_valid, accept, release_own;
  logic [WIDTH-1:0] own_data;

  fifo_wr_arbiter_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .any_req   (any_req)
  );

  // Mux the owner's valid/data; owner always stays below NREQ.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == ID_W'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_inc = (owner == ID_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign grant_id  = owner;
  assign busy      = (state == ST_OWN);

  // Next state and write-port outputs; ready depends only on owner/full, never on valid.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    fifo_wr     = 1'b0;
    fifo_data   = '0;
    accept      = 1'b0;
    release_own = 1'b0;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_OWN;
      ST_OWN: begin
        for (int i = 0; i < NREQ; i++)
          req_ready[i] = (owner == ID_W'(i)) && !fifo_full;
        fifo_wr     = own_valid && !fifo_full;
        fifo_data   = own_data;
        accept      = fifo_wr;
        // A full FIFO freezes the grant: no write, no count, no release.
        release_own = (accept && (burst_cnt == CNT_W'(MAX_BURST - 1))) ||
                      (!own_valid && !fifo_full);
        if (release_own) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping: owner/count load on grant, count on accept, pointer on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && any_req) begin
        owner     <= pick;
        burst_cnt <= '0;
      end
      if (accept)      burst_cnt <= burst_cnt + 1'b1;
      if (release_own) rr_ptr    <= owner_inc;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a grant-level reference model.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 8, NREQ = 4, ID_W = 2, MB = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       valid;
  logic [NREQ*WIDTH-1:0] data;
  logic                  full;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_data;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (valid),
    .req_data  (data),
    .req_ready (req_ready),
    .fifo_full (full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the port (-1 = nobody), words sent in this grant,
  // who was last granted, and who gets first look at the next grant.
  int m_owner, m_sent, m_last, m_next;

  // Observed/expected output vectors: {ready[15:12], wr[11], data[10:3], gid[2:1], busy[0]}
  logic [15:0] obs_vec, exp_vec;
  logic [9:0]  wq[$];   // observed writes {grant_id, data}

  task automatic model_reset();
    m_owner = -1; m_sent = 0; m_last = 0; m_next = 0;
  endtask

  task automatic model_eval();
    logic [3:0] rdy;
    logic       wr;
    logic [7:0] d;
    if (m_owner < 0) begin
      exp_vec = {4'b0, 1'b0, 8'h00, 2'(m_last), 1'b0};
    end else begin
      rdy     = full ? 4'b0 : (4'b1 << m_owner);
      wr      = valid[m_owner] && !full;
      d       = data[m_owner*WIDTH +: WIDTH];
      exp_vec = {rdy, wr, d, 2'(m_last), 1'b1};
    end
  endtask

  task automatic model_step();
    bit found;
    int idx;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_next + k) % NREQ;
        if (!found && valid[idx]) begin
          found = 1; m_owner = idx; m_last = idx; m_sent = 0;
        end
      end
    end else if (!full) begin
      if (valid[m_owner]) m_sent++;
      if (!valid[m_owner] || m_sent == MB) begin
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, advance the model, end just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    obs_vec = {req_ready, fifo_wr, fifo_data, grant_id, busy};
    if (fifo_wr) wq.push_back({grant_id, fifo_data});
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    valid   = '0;
    full    = 1'b0;
    #2;
    model_reset();
    reset_n = 1'b1;
    wq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid   = 4'hF;
    full    = 1'b0;
    data    = $urandom;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      if ({req_ready, fifo_wr, fifo_data, grant_id, busy} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs got=%h want=0000",
                 {req_ready, fifo_wr, fifo_data, grant_id, busy});
      end
      checks++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_release c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
    end
    if (obs_vec[2:1] !== 2'd0 || obs_vec[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_grant gid=%0d busy=%b want gid=0 busy=1", obs_vec[2:1], obs_vec[0]);
    end
    checks++;
  endtask

  task automatic test_single_stream();
    int        idx;
    logic [9:0] pat;
    apply_reset();
    idx = 0;
    pat = '0;
    for (int c = 0; c < 10; c++) begin
      data      = $urandom;
      data[23:16] = 8'(8'hA0 + idx);
      valid     = (idx < 6) ? 4'b0100 : 4'b0000;
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stream c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
      pat[c] = obs_vec[11];
      if (obs_vec[11]) idx++;
    end
    if (pat !== 10'b0011011110) begin
      errors++;
      $display("FAIL stream_wr_pattern got=%b want=%b", pat, 10'b0011011110);
    end
    checks++;
    if (wq.size() != 6) begin
      errors++;
      $display("FAIL stream_count got=%0d want=6", wq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (wq[i] !== {2'd2, 8'(8'hA0 + i)}) begin
          errors++;
          $display("FAIL stream_word i=%0d got=%h want=%h", i, wq[i], {2'd2, 8'(8'hA0 + i)});
        end
      end
    end
    checks++;
  endtask

  task automatic test_all_valid();
    apply_reset();
    valid = 4'hF;
    for (int c = 0; c < 25; c++) begin
      data = $urandom;
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL all_valid c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
    end
    // 25 cycles = 1 leading idle + 5 grants of 4 writes + 4 single-cycle bubbles.
    if (wq.size() != 20) begin
      errors++;
      $display("FAIL all_valid_count got=%0d want=20", wq.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        if (wq[i][9:8] !== 2'((i / 4) % 4)) begin
          errors++;
          $display("FAIL all_valid_order i=%0d got=%0d want=%0d", i, wq[i][9:8], (i / 4) % 4);
        end
      end
    end
    checks++;
  endtask

  task automatic test_full_stall();
    apply_reset();
    valid = 4'b0010;
    for (int c = 0; c < 9; c++) begin
      data = $urandom;
      full = (c >= 3 && c < 6);
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL stall c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
      if (full && (obs_vec[15:11] !== 5'b0 || obs_vec[2:1] !== 2'd1)) begin
        errors++;
        $display("FAIL stall_hold c=%0d ready_wr=%b gid=%0d want ready_wr=00000 gid=1",
                 c, obs_vec[15:11], obs_vec[2:1]);
      end
      if (full) checks++;
    end
    // Two words before the stall, two after, then the grant ends.
    if (wq.size() != 4 || obs_vec[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume writes=%0d busy=%b want writes=4 busy=0", wq.size(), obs_vec[0]);
    end
    checks++;
  endtask

  task automatic test_drop_wrap();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      data  = $urandom;
      valid = (c == 0) ? 4'b1000 : (c < 3) ? 4'b1001 : 4'b0001;
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL drop c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
    end
    if (wq.size() != 3 || wq[0][9:8] !== 2'd3 || wq[1][9:8] !== 2'd3 || wq[2][9:8] !== 2'd0) begin
      errors++;
      $display("FAIL drop_wrap writes=%0d last_gid=%0d want writes=3 gids 3,3,0",
               wq.size(), obs_vec[2:1]);
    end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    valid = 4'b0001;
    data  = $urandom;
    repeat (3) tick();
    #1;
    reset_n = 1'b0;
    #1;
    if ({req_ready, fifo_wr, fifo_data, grant_id, busy} !== 16'h0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0000", {req_ready, fifo_wr, fifo_data, grant_id, busy});
    end
    checks++;
    model_reset();
    reset_n = 1'b1;
    valid   = 4'b0110;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_restart c=%0d got=%h want=%h", c, obs_vec, exp_vec);
      end
      checks++;
    end
    if (obs_vec[2:1] !== 2'd1 || obs_vec[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_grant gid=%0d busy=%b want gid=1 busy=1", obs_vec[2:1], obs_vec[0]);
    end
    checks++;
  endtask

  task automatic test_random();
    apply_reset();
    valid = '0;
    for (int c = 0; c < 400; c++) begin
      // Mostly sticky valids so bursts run to their limit, with occasional drops.
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 4) == 0) valid[i] = ~valid[i];
      data = $urandom;
      full = ($urandom_range(0, 3) == 0);
      tick();
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random c=%0d v=%b f=%b got=%h want=%h", c, valid, full, obs_vec, exp_vec);
      end
      checks++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    valid   = '0;
    data    = '0;
    full    = 1'b0;
    test_reset();
    test_single_stream();
    test_all_valid();
    test_full_stall();
    test_drop_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO among NREQ producers.
- Round-robin arbitration; the granted producer may write a burst of up to MAX_BURST words, then the grant rotates.
- Sits between the producer blocks and the FIFO's data_in/wr/full pins. Read side untouched.

Parameters:
- WIDTH, 8, bits per data word; matches the FIFO element width.
- NREQ, 4, number of requesters; legal range 2..4.
- ID_W, 2, width of grant_id; NREQ <= 2**ID_W.
- MAX_BURST, 4, max accepted writes per grant; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester word-available.
- req_data  in  NREQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  word accepted this cycle when valid&ready.
- fifo_full  in  1  FIFO full flag.
- fifo_wr  out  1  FIFO write strobe.
- fifo_data  out  WIDTH  FIFO write data.
- grant_id  out  ID_W  current/last owner index.
- busy  out  1  high in OWN state.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
  - Outputs at reset: req_ready=0, fifo_wr=0, fifo_data=0, grant_id=0, busy=0.
  - Deassertion takes effect at the next clk edge.
- State IDLE:
  - All req_ready=0, fifo_wr=0, fifo_data=0.
  - If any req_valid: owner <= first index i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Same edge: burst_cnt <= 0, state <= OWN.
- State OWN (busy=1, grant_id=owner):
  - req_ready[owner] = !fifo_full; all other ready bits are 0.
  - fifo_wr = req_valid[owner] & !fifo_full. fifo_data = req_data[owner] (combinational).
  - Accepted write: burst_cnt <= burst_cnt+1.
  - Release to IDLE and set rr_ptr <= (owner+1) mod NREQ when either:
    - a write is accepted with burst_cnt == MAX_BURST-1, or
    - req_valid[owner]=0 and fifo_full=0 (owner has nothing to send).
  - fifo_full=1: hold OWN, no write, no count, no release. A requester stalled by full is not preempted.
- Latency: request in IDLE at cycle t → owner set at edge t+1 → first write possible in cycle t+1.
  - One-cycle IDLE bubble between grants; each grant costs at least 1 bubble.
- Fairness: any persistently valid requester is granted within NREQ-1 other grants.
- Simultaneous requests: resolved purely by rr_ptr order.
- Requesters asserting valid while not granted: no effect, data ignored, ready=0.
- MAX_BURST=1: release after every accepted write.
- rr_ptr and owner wrap modulo NREQ, not 2**ID_W.
- Reset mid-burst: immediate return to reset values; the partially sent burst is not resumed.
- No combinational path from req_valid to req_ready. fifo_wr depends on req_valid[owner] and fifo_full only.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=0, ST_OWN=1;
  - default WIDTH=8, NREQ=4, MAX_BURST=4.
- One sub-module: rr_pick (combinational).
  - Inputs: req_valid, rr_ptr.
  - Outputs: pick index and any_req.
  - Reusable by future read-side schedulers.

Test Plan:
- Reset with req_valid=4'b1111 held → all outputs 0 while reset_n=0; first grant_id=0 one cycle after release.
- Only req 2 valid, data 8'hA0..A5 streaming, MAX_BURST=4 → fifo_wr for A0..A3, then 1 idle cycle, then grant 2 again for A4, A5.
- All four valid continuously → grant order 0,1,2,3,0, each 4 writes; fifo_wr low exactly one cycle between grants.
- Owner 1 mid-burst, fifo_full=1 for 3 cycles → fifo_wr=0 and req_ready=0 for those cycles, grant_id stays 1, burst resumes with remaining count.
- Owner 3 drops valid after 2 words → release, next grant goes to valid requester 0 (rr wrap), not 3.
- Pull reset_n low while burst_cnt=2 → outputs 0 asynchronously (before next clk); after release arbitration restarts at rr_ptr=0.
